fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch front end for the rv32i pipeline. Owns the fetch PC, runs a one-outstanding-request handshake with instruction memory, and buffers fetched {pc, instr} pairs in a small FIFO. The decode/datapath stage consumes them through a valid/ready interface. Redirects from the datapath's PC mux (branch/jump target, already resolved) flush the buffer and restart fetch.

## Interface
- RESET_PC, 32'h6000_0000: first fetch address after reset.
- FIFO_DEPTH, 2: fetch buffer entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- imem_address  out  32  fetch address; stable while imem_read=1 until imem_resp.
- imem_read  out  1  request strobe; held high until imem_resp.
- imem_rdata  in  32  instruction word; valid only when imem_resp=1.
- imem_resp  in  1  single-cycle response pulse.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0 internally.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head this cycle.
- out_pc  out  32  PC of head instruction.
- out_instr  out  32  head instruction word.

## Operation
- Registers:
  - pc_q: next address to fetch.
  - req_addr_q: address currently on the bus.
  - FIFO entries, plus count 0..FIFO_DEPTH.
- FSM states:
  - IDLE: imem_read=0. If space_ok, latch req_addr_q<=pc_q and go to WAIT.
  - WAIT: imem_read=1, imem_address=req_addr_q.
    - On imem_resp, push {req_addr_q, imem_rdata} and set pc_q<=req_addr_q+4.
    - Then, if space_ok, issue the next request back-to-back: req_addr_q<=pc_q+4, stay in WAIT. Otherwise go to IDLE.
  - FLUSH: imem_read=1 with the old req_addr_q. On imem_resp, drop the data and go to IDLE.
- space_ok = (count after this cycle's push/pop) < FIFO_DEPTH. A response therefore never meets a full FIFO.
- Pop occurs when out_valid & out_ready. Push and pop may happen in the same cycle, including at count==FIFO_DEPTH-1 or FIFO_DEPTH.
- Redirect has priority over every other event:
  - FIFO is cleared and any same-cycle pop is ignored.
  - pc_q<=redirect_pc&~3.
  - In WAIT without imem_resp: go to FLUSH, holding the bus request unchanged.
  - In WAIT with imem_resp the same cycle: discard the response and go to IDLE.
  - In FLUSH: update pc_q only and stay in FLUSH.
  - In IDLE: stay in IDLE; the new address issues next cycle.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0.
- Reset values:
  - state=IDLE, pc_q=RESET_PC, req_addr_q=RESET_PC, count=0.
  - imem_read=0, out_valid=0, out_pc=0, out_instr=0.
- Reset asserted mid-request abandons the request immediately, with no FLUSH. The memory is reset by the same rst.

## Timing
- Reset released in cycle N: imem_read=1 with RESET_PC in N+1.
- imem_resp in cycle N: out_valid=1 with that word in N+1. FIFO outputs are registered; there is no rdata→out path.
- With single-cycle memory and out_ready=1, sustained throughput is 1 instruction/cycle.
- redirect_valid in cycle N: out_valid=0 in N+1. The redirect address appears on imem_address:
  - in N+1 if the state was IDLE or imem_resp arrived in N;
  - otherwise the cycle after the outstanding response returns.
- imem_address and imem_read are driven directly from registers. No combinational path runs from any input to the imem outputs.

## Configuration
- FETCH_PERF_CNT_EN defined: adds two ports and their counters.
  - perf_stall_cycles out 32: counts cycles in WAIT/FLUSH without imem_resp.
  - perf_flush_count out 32: counts redirect_valid cycles.
  - Both reset to 0 and wrap on overflow.
- FETCH_PERF_CNT_EN undefined: the ports and counters are absent. Functional behaviour is identical.

## Structure
- Add to package rv32i_types:
  - fetch_pkt_t struct {pc, instr}.
  - fetch_state_t enum {IDLE, WAIT, FLUSH}.
- Sub-module fetch_fifo, parameterised on depth and element type fetch_pkt_t.
  - Ports: push, pop, clear, head, count.
  - clear has priority over push and pop.
- The FSM and PC logic live in fetch_stage.

## Test plan
- Reset then single-cycle resp, out_ready=1 → first request at 32'h6000_0000; out_pc sequence 6000_0000, 6000_0004, 6000_0008 on consecutive cycles.
- out_ready=0 for 10 cycles → count saturates at 2; imem_read drops to 0; no lost or duplicated pc when out_ready returns.
- redirect_pc=32'h6000_0103 while WAIT with 3-cycle memory latency → FLUSH; stale word dropped; next request at 6000_0100; first out_pc=6000_0100.
- redirect_valid and imem_resp in the same cycle → response discarded; out_valid=0 next cycle; redirect address on the bus next cycle.
- Redirect to 32'hFFFF_FFFC → fetches FFFF_FFFC then 0000_0000.
- rst low during WAIT, then released → imem_read=0 for the reset cycles; refetch from RESET_PC; perf counters at 0 when FETCH_PERF_CNT_EN is defined.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: fetch packet, fetch FSM states and PC helpers.
package rv32i_types;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLUSH
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO holding fetched packets; clear beats push and pop.
// Storage is reset so the head reads as zero straight out of reset.
module fetch_fifo
  import rv32i_types::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_pkt_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rv32i fetch front end: PC, one-outstanding imem handshake and fetch buffer.
// Optional FETCH_PERF_CNT_EN adds stall-cycle and flush performance counters.
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h6000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   redirect_aligned;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          push, pop, space_ok;
  fetch_pkt_t    push_pkt, head;

  assign redirect_aligned = align_pc(redirect_pc);
  assign out_valid        = (count != '0);
  assign pop              = out_valid && out_ready && !redirect_valid;
  assign push             = (state_q == WAIT) && imem_resp && !redirect_valid;
  assign count_after      = count + CW'(push) - CW'(pop);
  assign space_ok         = (count_after < CW'(FIFO_DEPTH));
  assign push_pkt         = '{pc: req_addr_q, instr: imem_rdata};
  assign out_pc           = head.pc;
  assign out_instr        = head.instr;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_pkt_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (push),
    .din   (push_pkt),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // In IDLE the bus address tracks redirects early so it is visible one cycle later.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d       = redirect_aligned;
          req_addr_d = redirect_aligned;
        end else if (space_ok) begin
          req_addr_d = pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_aligned;
          if (imem_resp) begin
            req_addr_d = redirect_aligned;
            state_d    = IDLE;
          end else begin
            state_d = FLUSH;
          end
        end else if (imem_resp) begin
          pc_d = req_addr_q + PC_STEP;
          if (space_ok) req_addr_d = req_addr_q + PC_STEP;
          else          state_d    = IDLE;
        end
      end
      FLUSH: begin
        if (redirect_valid) pc_d = redirect_aligned;
        if (imem_resp) begin
          req_addr_d = redirect_valid ? redirect_aligned : pc_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_read    = (state_q != IDLE);
    imem_address = req_addr_q;
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if ((state_q != IDLE) && !imem_resp) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (redirect_valid) perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a variable-latency instruction memory model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h6000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          mem_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_pc;
  logic        prev_rst = 1'b0;
  logic        prev_read = 1'b0;
  logic        prev_resp = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] old_addr;

  fetch_stage #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .imem_address      (imem_address),
    .imem_read         (imem_read),
    .imem_rdata        (imem_rdata),
    .imem_resp         (imem_resp),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_instr         (out_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'hC3A5_0F96;
  endfunction

  // Memory model: answers lat cycles after a request is first seen, reset with rst.
  always @(posedge clk) begin
    #3;
    if (!rst) begin
      imem_resp  = 1'b0;
      imem_rdata = '0;
      mem_cnt    = 0;
    end else if (imem_read) begin
      if (mem_cnt >= lat - 1) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_word(imem_address);
        mem_cnt    = 0;
      end else begin
        imem_resp  = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        mem_cnt    = mem_cnt + 1;
      end
    end else begin
      imem_resp = 1'b0;
      mem_cnt   = 0;
    end
  end

  // Monitor: pops the scoreboard on each accepted output and checks bus stability.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && !redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL pop_unexpected actual pc=%h instr=%h required=no output", out_pc, out_instr);
      end else begin
        mon_pc = exp_q.pop_front();
        if (out_pc !== mon_pc || out_instr !== mem_word(mon_pc)) begin
          errors++;
          $display("[TB] FAIL pop_data actual pc=%h instr=%h required pc=%h instr=%h",
                   out_pc, out_instr, mon_pc, mem_word(mon_pc));
        end
      end
    end
    if (prev_rst && prev_read && !prev_resp) begin
      checks++;
      if (imem_read !== 1'b1 || imem_address !== prev_addr) begin
        errors++;
        $display("[TB] FAIL bus_hold actual read=%b addr=%h required read=1 addr=%h",
                 imem_read, imem_address, prev_addr);
      end
    end
    prev_rst  = rst;
    prev_read = imem_read;
    prev_resp = imem_resp;
    prev_addr = imem_address;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst_v, input logic ready_v,
                               input logic redir_v, input logic [31:0] redir_pc_v);
    rst            = rst_v;
    out_ready      = ready_v;
    redirect_valid = redir_v;
    redirect_pc    = redir_pc_v;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic loadExpected(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(i * 4));
  endtask

  task automatic waitMem(input int want, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (imem_read && mem_cnt == want) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s actual=timeout required=request in flight", name);
    end
  endtask

  task automatic waitValid(input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (out_valid) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s actual=timeout required=out_valid", name);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    repeat (3) step();
    checkOutput("reset_read", 32'(imem_read), 32'd0);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_pc", out_pc, 32'd0);
    checkOutput("reset_out_instr", out_instr, 32'd0);
    checkOutput("reset_addr", imem_address, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("reset_perf_stall", perf_stall_cycles, 32'd0);
    checkOutput("reset_perf_flush", perf_flush_count, 32'd0);
`endif

    // Streaming from reset with single-cycle memory
    loadExpected(RESET_PC, 64);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    step();
    checkOutput("first_req_read", 32'(imem_read), 32'd1);
    checkOutput("first_req_addr", imem_address, RESET_PC);
    step();
    checkOutput("stream_valid0", 32'(out_valid), 32'd1);
    checkOutput("stream_pc0", out_pc, RESET_PC);
    step();
    checkOutput("stream_valid1", 32'(out_valid), 32'd1);
    checkOutput("stream_pc1", out_pc, RESET_PC + 32'd4);
    step();
    checkOutput("stream_valid2", 32'(out_valid), 32'd1);
    checkOutput("stream_pc2", out_pc, RESET_PC + 32'd8);

    // Backpressure: buffer fills, requests stop, nothing lost on release
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    repeat (10) step();
    checkOutput("stall_read", 32'(imem_read), 32'd0);
    checkOutput("stall_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_head_pc", out_pc, RESET_PC + 32'd8);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    repeat (6) step();

    // Redirect while a slow request is outstanding
    lat = 3;
    waitMem(0, "flush_wait");
    old_addr = imem_address;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h6000_0103);
    loadExpected(32'h6000_0100, 64);
    step();
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_read", 32'(imem_read), 32'd1);
    checkOutput("flush_addr_hold", imem_address, old_addr);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    waitValid("flush_first_wait");
    checkOutput("flush_first_pc", out_pc, 32'h6000_0100);
    repeat (8) step();

    // Redirect in the same cycle as a response
    waitMem(2, "same_wait");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h6000_0200);
    loadExpected(32'h6000_0200, 64);
    step();
    checkOutput("same_valid", 32'(out_valid), 32'd0);
    checkOutput("same_read", 32'(imem_read), 32'd0);
    checkOutput("same_addr", imem_address, 32'h6000_0200);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    step();
    checkOutput("same_reissue_read", 32'(imem_read), 32'd1);
    checkOutput("same_reissue_addr", imem_address, 32'h6000_0200);
    repeat (8) step();

    // PC wrap at the top of the address space
    lat = 1;
    repeat (4) step();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    loadExpected(32'hFFFF_FFFC, 64);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    waitValid("wrap_wait");
    checkOutput("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    step();
    checkOutput("wrap_pc1", out_pc, 32'h0000_0000);
    step();
    checkOutput("wrap_pc2", out_pc, 32'h0000_0004);
    repeat (4) step();

    // Reset in the middle of an outstanding request
    lat = 3;
    waitMem(1, "rst_wait");
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    step();
    checkOutput("rst_read", 32'(imem_read), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_addr", imem_address, RESET_PC);
    step();
    checkOutput("rst_read2", 32'(imem_read), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("rst_perf_stall", perf_stall_cycles, 32'd0);
    checkOutput("rst_perf_flush", perf_flush_count, 32'd0);
`endif
    loadExpected(RESET_PC, 64);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    step();
    checkOutput("refetch_read", 32'(imem_read), 32'd1);
    checkOutput("refetch_addr", imem_address, RESET_PC);
    waitValid("refetch_wait");
    checkOutput("refetch_pc", out_pc, RESET_PC);
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
